// File: rtl/vp_pkg.sv
// Shared types and constants for the vp video pipeline stages.
// Pixel is {R,G,B}; every stage adds VP_LATENCY clocks.
package vp_pkg;
   typedef logic [23:0] pixel_t;

   localparam int     VP_X_W     = 11;
   localparam int     VP_Y_W     = 11;
   localparam int     VP_LATENCY = 2;
   localparam pixel_t COLOR_RED  = 24'hFF0000;

   function automatic logic is_fg(
      input pixel_t     p,
      input logic [7:0] th
   );
      return p[23:16] >= th;
   endfunction
endpackage

// File: rtl/vp_pos_counter.sv
// de/vsync edge detect and saturating pixel position counters.
// x/y describe the pixel registered in the same cycle (stage 1).
module vp_pos_counter
   import vp_pkg::*;
#(
   parameter int X_W = VP_X_W,
   parameter int Y_W = VP_Y_W
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           de,
   input  logic           vsync,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           de_q,
   output logic           vs_q,
   output logic           frame_end
);

   logic line_start;
   logic line_end;
   logic vs_rise;

   assign line_start = de & ~de_q;
   assign line_end   = ~de & de_q;
   assign vs_rise    = vsync & ~vs_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         x         <= '0;
         y         <= '0;
         de_q      <= 1'b0;
         vs_q      <= 1'b0;
         frame_end <= 1'b0;
      end else begin
         de_q      <= de;
         vs_q      <= vsync;
         frame_end <= vs_rise;
         if (line_start)
            x <= '0;
         else if (de && x != '1)
            x <= x + 1'b1;
         else if (line_end)
            x <= '0;
         if (vs_rise)
            y <= '0;
         else if (line_end && y != '1)
            y <= y + 1'b1;
      end
   end

endmodule

// File: rtl/bbox_overlay.sv
// Foreground bounding-box tracker; draws last frame's box on this one.
// Optional BBOX_CROSSHAIR_EN adds a centre crosshair inside the box.
module bbox_overlay
   import vp_pkg::*;
#(
   parameter int         X_W       = VP_X_W,
   parameter int         Y_W       = VP_Y_W,
   parameter logic [7:0] FG_THRESH = 8'd128,
   parameter pixel_t     BOX_COLOR = COLOR_RED
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   de,
   input  logic   hsync,
   input  logic   vsync,
   input  pixel_t pixel_in,
   output logic   de_out,
   output logic   hsync_out,
   output logic   vsync_out,
   output pixel_t pixel_out
);

   logic [X_W-1:0] x;
   logic [Y_W-1:0] y;
   logic           de1;
   logic           vs1;
   logic           hs1;
   logic           frame_end;
   pixel_t         pix1;

   vp_pos_counter #(
      .X_W (X_W),
      .Y_W (Y_W)
   ) u_pos (
      .clk       (clk),
      .rst       (rst),
      .de        (de),
      .vsync     (vsync),
      .x         (x),
      .y         (y),
      .de_q      (de1),
      .vs_q      (vs1),
      .frame_end (frame_end)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pix1 <= '0;
         hs1  <= 1'b0;
      end else begin
         pix1 <= pixel_in;
         hs1  <= hsync;
      end
   end

   logic [X_W-1:0] xmin, xmax, nxmin, nxmax;
   logic [Y_W-1:0] ymin, ymax, nymin, nymax;
   logic           found, nfound;
   logic           fg;

   assign fg = de1 & is_fg(pix1, FG_THRESH);

   always_comb begin
      nxmin  = xmin;
      nxmax  = xmax;
      nymin  = ymin;
      nymax  = ymax;
      nfound = found;
      if (fg) begin
         nxmin  = (x < xmin) ? x : xmin;
         nxmax  = (x > xmax) ? x : xmax;
         nymin  = (y < ymin) ? y : ymin;
         nymax  = (y > ymax) ? y : ymax;
         nfound = 1'b1;
      end
   end

   logic [X_W-1:0] bxmin, bxmax;
   logic [Y_W-1:0] bymin, bymax;
   logic           box_vld;

   // A pixel arriving with the frame-end pulse closes out the old frame.
   always_ff @(posedge clk) begin
      if (rst || frame_end) begin
         xmin  <= '1;
         xmax  <= '0;
         ymin  <= '1;
         ymax  <= '0;
         found <= 1'b0;
      end else begin
         xmin  <= nxmin;
         xmax  <= nxmax;
         ymin  <= nymin;
         ymax  <= nymax;
         found <= nfound;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bxmin   <= '0;
         bxmax   <= '0;
         bymin   <= '0;
         bymax   <= '0;
         box_vld <= 1'b0;
      end else if (frame_end) begin
         box_vld <= nfound;
         if (nfound) begin
            bxmin <= nxmin;
            bxmax <= nxmax;
            bymin <= nymin;
            bymax <= nymax;
         end
      end
   end

   logic in_x, in_y, on_x, on_y;
   logic mark;

   assign in_x = (x >= bxmin) && (x <= bxmax);
   assign in_y = (y >= bymin) && (y <= bymax);
   assign on_x = (x == bxmin) || (x == bxmax);
   assign on_y = (y == bymin) || (y == bymax);

`ifdef BBOX_CROSSHAIR_EN
   logic [X_W-1:0] cx;
   logic [Y_W-1:0] cy;
   logic [X_W:0]   xsum;
   logic [Y_W:0]   ysum;

   assign xsum = {1'b0, nxmin} + {1'b0, nxmax};
   assign ysum = {1'b0, nymin} + {1'b0, nymax};

   always_ff @(posedge clk) begin
      if (rst) begin
         cx <= '0;
         cy <= '0;
      end else if (frame_end && nfound) begin
         cx <= xsum[X_W:1];
         cy <= ysum[Y_W:1];
      end
   end

   assign mark = box_vld & de1 &
                 ((on_x & in_y) | (on_y & in_x) |
                  ((x == cx) & in_y) | ((y == cy) & in_x));
`else
   assign mark = box_vld & de1 &
                 ((on_x & in_y) | (on_y & in_x));
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         de_out    <= 1'b0;
         hsync_out <= 1'b0;
         vsync_out <= 1'b0;
         pixel_out <= '0;
      end else begin
         de_out    <= de1;
         hsync_out <= hs1;
         vsync_out <= vs1;
         pixel_out <= mark ? BOX_COLOR : pix1;
      end
   end

endmodule

// File: tb/tb_bbox_overlay.sv
// Directed frame-level bench for bbox_overlay; every output cycle is
// compared against a 2-deep expected pipeline built from hand bounds.
module tb_bbox_overlay;
   import vp_pkg::*;

   localparam int W = 64;
   localparam int H = 48;

   logic   clk = 1'b0;
   logic   rst, de, hsync, vsync;
   pixel_t pixel_in;
   logic   de_out, hsync_out, vsync_out;
   pixel_t pixel_out;

   always #5 clk = ~clk;

   bbox_overlay dut (
      .clk       (clk),
      .rst       (rst),
      .de        (de),
      .hsync     (hsync),
      .vsync     (vsync),
      .pixel_in  (pixel_in),
      .de_out    (de_out),
      .hsync_out (hsync_out),
      .vsync_out (vsync_out),
      .pixel_out (pixel_out)
   );

   int errs   = 0;
   int checks = 0;
   int cur_f  = 0;
   int cur_x  = 0;
   int cur_y  = 0;

   bit ebv = 0;
   int bx0, bx1, by0, by1;
   logic [26:0] s1 = '0;

   task automatic check(input string tag,
                        input logic [26:0] got,
                        input logic [26:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s frame=%0d near x=%0d y=%0d got=%h exp=%h",
                  tag, cur_f, cur_x, cur_y, got, exp);
      end
   endtask

   function automatic bit ovl(input int x, input int y);
      bit inx, iny, b;
      inx = (x >= bx0) && (x <= bx1);
      iny = (y >= by0) && (y <= by1);
      b = ((x == bx0 || x == bx1) && iny) ||
          ((y == by0 || y == by1) && inx);
`ifdef BBOX_CROSSHAIR_EN
      b = b || (x == (bx0 + bx1) / 2 && iny) ||
               (y == (by0 + by1) / 2 && inx);
`endif
      return ebv && b;
   endfunction

   function automatic pixel_t mk(input bit fg);
      logic [7:0]  r;
      logic [15:0] gb;
      gb = 16'($urandom);
      if (fg) r = 8'(128 + $urandom_range(0, 127));
      else    r = 8'($urandom_range(0, 127));
      return {r, gb};
   endfunction

   task automatic cyc(input logic r, input logic d,
                      input logic h, input logic v,
                      input pixel_t p, input bit ov);
      logic [26:0] cur, eo;
      cur = {d, h, v, (ov ? COLOR_RED : p)};
      rst = r; de = d; hsync = h; vsync = v; pixel_in = p;
      @(posedge clk);
      #1;
      if (r) begin
         eo = '0;
         s1 = '0;
      end else begin
         eo = s1;
         s1 = cur;
      end
      check(r ? "rst" : "pix",
            {de_out, hsync_out, vsync_out, pixel_out}, eo);
   endtask

   task automatic frame(input int fn,
                        input bit fg_en,
                        input int fx0, input int fx1,
                        input int fy0, input int fy1,
                        input bit bv,
                        input int b0, input int b1,
                        input int c0, input int c1,
                        input int rst_line);
      bit fg;
      cur_f = fn;
      ebv = bv; bx0 = b0; bx1 = b1; by0 = c0; by1 = c1;
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, mk(i[0]), 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, mk(i[0]), 0);
      for (int y = 0; y < H; y++) begin
         cur_y = y;
         if (y == rst_line) begin
            cyc(1, 0, 0, 0, mk(1), 0);
            cyc(1, 0, 0, 0, mk(0), 0);
            ebv = 0;
         end
         for (int x = 0; x < W; x++) begin
            cur_x = x;
            fg = fg_en && x >= fx0 && x <= fx1 &&
                 y >= fy0 && y <= fy1;
            cyc(0, 1, 0, 0, mk(fg), ovl(x, y));
         end
         for (int i = 0; i < 6; i++)
            cyc(0, 0, (i >= 2 && i < 5), 0, mk(i[0]), 0);
      end
   endtask

   initial begin
      rst = 1; de = 0; hsync = 0; vsync = 0; pixel_in = '0;
      // reset with random inputs, then plain 2-clk delay
      for (int i = 0; i < 4; i++)
         cyc(1, 1'($urandom), 1'($urandom), 1'($urandom),
             24'($urandom), 0);
      for (int i = 0; i < 20; i++)
         cyc(0, 1'($urandom), 1'($urandom), 0, 24'($urandom), 0);
      cyc(1, 0, 0, 0, 24'h0, 0);
      cyc(1, 0, 0, 0, 24'h0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, mk(0), 0);

      // square: first frame untouched, second shows box
      frame(1, 1, 10, 20, 5, 9, 0, 0, 0, 0, 0, -1);
      frame(2, 1, 10, 20, 5, 9, 1, 10, 20, 5, 9, -1);
      // empty frames
      frame(3, 0, 0, 0, 0, 0, 1, 10, 20, 5, 9, -1);
      frame(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
      // single pixel at the far corner
      frame(5, 1, 63, 63, 47, 47, 0, 0, 0, 0, 0, -1);
      frame(6, 0, 0, 0, 0, 0, 1, 63, 63, 47, 47, -1);
      // reset in the middle of a box frame
      frame(7, 1, 10, 20, 5, 9, 0, 0, 0, 0, 0, 20);
      frame(8, 1, 10, 20, 5, 9, 0, 0, 0, 0, 0, -1);
      frame(9, 0, 0, 0, 0, 0, 1, 10, 20, 5, 9, -1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, mk(0), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
